// File: rtl/operand_entry.sv
// Operand entry front end for the GCD demo board.
// Conditions the Center pushbutton into a single clean press pulse,
// captures two non-zero switch operands, launches the GCD core once it
// is idle, and shows the current phase on the LEDs.
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        CLK100MHZ,
    input  logic        Reset,
    input  logic [15:0] SW,
    input  logic        Center,
    input  logic        busy,
    input  logic        done,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        start,
    output logic [3:0]  LED
);

    // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] LED_A    = 4'b0001;
    localparam logic [3:0] LED_B    = 4'b0010;
    localparam logic [3:0] LED_RUN  = 4'b0100;
    localparam logic [3:0] LED_SHOW = 4'b1000;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        SHOW   = 3'd4
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          lvl_q;
    logic          press;

    // Two-flop synchronizer; sync[1] is the only copy of Center used below.
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) sync <= 2'b00;
        else       sync <= {sync[0], Center};
    end

    // Debounce: the level follows the synchronized input only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (sync[1] == lvl) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            lvl <= sync[1];
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Registered rising-edge detect: one press per debounced 0->1, none on release.
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            lvl_q <= 1'b0;
            press <= 1'b0;
        end else begin
            lvl_q <= lvl;
            press <= lvl & ~lvl_q;
        end
    end

    // Phase sequencer; operands and LED pattern are registered with the state.
    // Presses outside GET_A/GET_B/SHOW and done outside RUN fall through unused.
    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            state <= GET_A;
            A     <= 16'h0000;
            B     <= 16'h0000;
            LED   <= LED_A;
        end else begin
            case (state)
                GET_A: if (press && SW != 16'h0000) begin
                    A     <= SW;
                    state <= GET_B;
                    LED   <= LED_B;
                end
                GET_B: if (press && SW != 16'h0000) begin
                    B     <= SW;
                    state <= LAUNCH;
                    LED   <= LED_RUN;
                end
                LAUNCH: if (!busy) begin
                    state <= RUN;
                end
                RUN: if (done) begin
                    state <= SHOW;
                    LED   <= LED_SHOW;
                end
                SHOW: if (press) begin
                    state <= GET_A;
                    LED   <= LED_A;
                end
                default: begin
                    state <= GET_A;
                    LED   <= LED_A;
                end
            endcase
        end
    end

    // Launch pulse lands in the first LAUNCH cycle the core reports idle;
    // the state leaves LAUNCH on that same edge, so it is exactly one cycle.
    assign start = (state == LAUNCH) && !busy;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed scenarios plus a randomized stretch,
// all compared every cycle against a behavioural model of the block.
module tb_operand_entry;

    localparam int N = 4;

    localparam int P_GETA   = 0;
    localparam int P_GETB   = 1;
    localparam int P_LAUNCH = 2;
    localparam int P_RUN    = 3;
    localparam int P_SHOW   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        center;
    logic        busy;
    logic        done;
    logic [15:0] a_o;
    logic [15:0] b_o;
    logic        start_o;
    logic [3:0]  led_o;

    always #5 clk = ~clk;

    operand_entry #(.DEBOUNCE_CYCLES(N)) dut (
        .CLK100MHZ(clk),
        .Reset    (rst),
        .SW       (sw),
        .Center   (center),
        .busy     (busy),
        .done     (done),
        .A        (a_o),
        .B        (b_o),
        .start    (start_o),
        .LED      (led_o)
    );

    int checks = 0;
    int passed = 0;
    int start_cnt = 0;

    // Reference model state
    bit          m_s1, m_s2;   // Center as seen one and two edges ago
    bit          m_lvl;        // accepted button level
    int          m_run;        // consecutive edges input disagreed with level
    bit          m_rise;       // level went high at the last edge
    bit          m_press;      // press visible to the sequencer at next edge
    int          m_phase;
    logic [15:0] m_a, m_b;

    function automatic logic [3:0] led_of(int ph);
        case (ph)
            P_GETA:  return 4'b0001;
            P_GETB:  return 4'b0010;
            P_SHOW:  return 4'b1000;
            default: return 4'b0100;
        endcase
    endfunction

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
        m_rise = 0; m_press = 0;
        m_phase = P_GETA; m_a = 16'h0; m_b = 16'h0;
    endfunction

    // Advance the model by one rising edge using the inputs in front of it.
    function automatic void model_edge();
        bit s_use = m_s2;
        bit pr    = m_press;
        m_s2 = m_s1;
        m_s1 = center;
        m_press = m_rise;
        m_rise = 0;
        if (s_use != m_lvl) begin
            m_run++;
            if (m_run == N) begin
                m_lvl = s_use;
                m_run = 0;
                m_rise = s_use;
            end
        end else begin
            m_run = 0;
        end
        case (m_phase)
            P_GETA:   if (pr && sw != 0) begin m_a = sw; m_phase = P_GETB; end
            P_GETB:   if (pr && sw != 0) begin m_b = sw; m_phase = P_LAUNCH; end
            P_LAUNCH: if (!busy) m_phase = P_RUN;
            P_RUN:    if (done) m_phase = P_SHOW;
            default:  if (pr) m_phase = P_GETA;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        logic exp_start;
        exp_start = (m_phase == P_LAUNCH) && !busy && !rst;
        check("cycle_outputs", {a_o, b_o, led_o, start_o},
              {m_a, m_b, led_of(m_phase), exp_start});
        if (start_o === 1'b1) start_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset from the middle of the low clock phase.
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 check("reset_async", {a_o, b_o, led_o, start_o}, {16'h0, 16'h0, 4'b0001, 1'b0});
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic press(input int hi, input int lo);
        center = 1'b1;
        repeat (hi) step();
        center = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        logic [15:0] sa, sb;
        bit found;

        rst = 1'b1; sw = 16'h0; center = 1'b0; busy = 1'b0; done = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {a_o, b_o, led_o, start_o}, {16'h0, 16'h0, 4'b0001, 1'b0});
        rst = 1'b0;

        // Two clean presses capture A then B and launch once.
        start_cnt = 0;
        sw = 16'h00F0;
        press(20, 20);
        check("capture_a", {a_o, led_o}, {16'h00F0, 4'b0010});
        sw = 16'h000F;
        press(20, 20);
        check("capture_b", {b_o, led_o}, {16'h000F, 4'b0100});
        check("start_once", start_cnt, 1);

        // Bouncing button never settles long enough for a press.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            center = ~center;
            step();
            step();
        end
        center = 1'b0;
        repeat (20) step();
        check("bounce_no_press", {a_o, led_o}, {16'h0, 4'b0001});

        // Zero operand is ignored; a non-zero one is taken.
        sw = 16'h0000;
        press(20, 20);
        check("zero_ignored", {a_o, led_o}, {16'h0, 4'b0001});
        sw = 16'h0005;
        press(20, 20);
        check("sw5_captured", {a_o, led_o}, {16'h0005, 4'b0010});

        // Busy core delays the launch.
        busy = 1'b1;
        sw = 16'($urandom_range(1, 16'hFFFF));
        center = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (m_phase == P_LAUNCH) found = 1;
        end
        check("reached_launch", found, 1);
        start_cnt = 0;
        repeat (10) step();
        check("no_start_while_busy", start_cnt, 0);
        busy = 1'b0;
        #1 check("start_on_idle", {start_o, led_o}, {1'b1, 4'b0100});
        step();
        check("run_next_cycle", {start_o, led_o}, {1'b0, 4'b0100});
        center = 1'b0;
        repeat (20) step();

        // Press coincident with done: done wins, press discarded.
        sa = a_o; sb = b_o;
        center = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (m_press) begin
                done = 1'b1;
                step();
                done = 1'b0;
                found = 1;
            end
        end
        check("coincident_seen", found, 1);
        check("show_after_done", led_o, 4'b1000);
        center = 1'b0;
        repeat (20) step();
        check("press_in_show_only", led_o, 4'b1000);
        press(20, 20);
        check("back_to_get_a", {a_o, b_o, led_o}, {sa, sb, 4'b0001});

        // Reset during RUN, then a stray done.
        sw = 16'h1111; press(20, 20);
        sw = 16'h2222; press(20, 20);
        check("in_run", {b_o, led_o}, {16'h2222, 4'b0100});
        do_reset();
        done = 1'b1; step(); done = 1'b0;
        repeat (5) step();
        check("done_after_reset_ignored", {a_o, b_o, led_o}, {16'h0, 16'h0, 4'b0001});

        // Button held through reset release: press lands N+3 edges later.
        sw = 16'h1234;
        center = 1'b1;
        do_reset();
        repeat (N + 3) step();
        check("held_not_yet", a_o, 16'h0);
        step();
        check("held_press", a_o, 16'h1234);
        center = 1'b0;
        repeat (20) step();

        // Randomized stretch, compared against the model every cycle.
        for (int r = 0; r < 60; r++) begin
            center = 1'($urandom_range(0, 1));
            sw     = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            busy   = 1'($urandom_range(0, 1));
            done   = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(1, 12)) step();
        end
        done = 1'b0;
        busy = 1'b0;
        repeat (5) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
